// File: rtl/sdram_frame_reader_pkg.sv
// Shared definitions for the SDRAM frame reader.
// - Default SDRAM data/address widths, kept in step with the controller's
//   Sdram_Params.h.
// - The reader FSM state type, plus a helper that tells whether a state
//   counts as "busy".
package sdram_frame_reader_pkg;

  localparam int SDRAM_DSIZE = 16;
  localparam int SDRAM_ASIZE = 22;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STREAM,
    ST_DRAIN,
    ST_FLUSH,
    ST_DONE
  } state_e;

  // DONE is excluded, so busy is already low in the cycle where done pulses.
  function automatic logic state_busy(state_e s);
    return (s == ST_LOAD) || (s == ST_STREAM) || (s == ST_DRAIN) || (s == ST_FLUSH);
  endfunction

endpackage

// File: rtl/sdram_rd_skid.sv
// Two-entry output buffer that sits between the SDRAM read FIFO and the
// pixel stream.
// Ports:
//   CTRL_CLK, RESET_N : clock and asynchronous active-low reset
//   i_clr             : drop all contents; takes priority over push
//   i_push, i_data    : write one word
//   o_data, o_valid,
//   i_ready           : stream output; a pop happens on o_valid & i_ready
//   o_occ             : current number of stored words (0..2)
module sdram_rd_skid #(
  parameter int DW = 16
) (
  input  logic          CTRL_CLK,
  input  logic          RESET_N,
  input  logic          i_clr,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [1:0]    o_occ
);

  logic [1:0][DW-1:0] r_mem;
  logic               r_wp, r_rp;
  logic [1:0]         r_occ;
  logic               w_pop;

  assign w_pop   = o_valid & i_ready;
  assign o_valid = (r_occ != 2'd0);
  assign o_data  = r_mem[r_rp];
  assign o_occ   = r_occ;

  // The upstream credit check never lets a push arrive while the buffer is full.
  always_ff @(posedge CTRL_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_mem <= '0;
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_occ <= 2'd0;
    end else if (i_clr) begin
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_occ <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wp] <= i_data;
        r_wp        <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_occ <= r_occ + {1'b0, i_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: rtl/sdram_frame_reader.sv
// Read-port client for one read side of the 4-port SDRAM controller.
// It programs the port window, pulses RD_LOAD, and drains exactly
// frame_words words into a valid/ready stream that carries m_last. It then
// pulses RD_LOAD again to throw away the words the controller prefetched
// past the frame.
// Ports:
//   CTRL_CLK, RESET_N          : clock (also the port's RDx_CLK) and async reset
//   start, abort               : single-cycle commands
//   frame_base, frame_words    : frame window
//   busy, done, aborted, err   : status
//   RD_ADDR, RD_MAX_ADDR,
//   RD_LENGTH, RD_LOAD         : controller port programming
//   RD, RD_DATA, RD_EMPTY,
//   RD_USE                     : controller read FIFO
//   m_data, m_valid, m_ready,
//   m_last                     : output stream
module sdram_frame_reader
  import sdram_frame_reader_pkg::*;
#(
  parameter int DSIZE       = SDRAM_DSIZE,
  parameter int ASIZE       = SDRAM_ASIZE,
  parameter int BURST_LEN   = 256,
  parameter int LOAD_CYCLES = 4
) (
  input  logic             CTRL_CLK,
  input  logic             RESET_N,
  input  logic             start,
  input  logic             abort,
  input  logic [ASIZE-1:0] frame_base,
  input  logic [ASIZE-1:0] frame_words,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             err,
  output logic [ASIZE-1:0] RD_ADDR,
  output logic [ASIZE-1:0] RD_MAX_ADDR,
  output logic [9:0]       RD_LENGTH,
  output logic             RD_LOAD,
  output logic             RD,
  input  logic [DSIZE-1:0] RD_DATA,
  input  logic             RD_EMPTY,
  input  logic [15:0]      RD_USE,
  output logic [DSIZE-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last
);

  localparam int CW = $clog2(LOAD_CYCLES);

  state_e           r_state, w_nxt;
  logic [ASIZE-1:0] r_words, r_rd_addr, r_rd_max;
  logic [9:0]       r_rd_len;
  logic [ASIZE:0]   r_issued, r_sent, w_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_rd_q, r_err, r_aborted;
  logic             w_ok, w_accept, w_reject, w_load, w_rd, w_clr, w_push, w_pop, w_cnt_end;
  logic [1:0]       w_occ;
  logic [2:0]       w_credit;
  logic             w_unused_use;

  // FIFO fill level is status only; the empty flag drives the read decision.
  assign w_unused_use = ^RD_USE;

  assign w_sum     = {1'b0, frame_base} + {1'b0, frame_words};
  assign w_ok      = (frame_words != '0) && ((frame_words & ASIZE'(BURST_LEN - 1)) == '0)
                     && !w_sum[ASIZE];
  assign w_accept  = start && (r_state == ST_IDLE) && w_ok;
  assign w_reject  = start && (r_state == ST_IDLE) && !w_ok;
  assign w_pop     = m_valid & m_ready;
  // Words already owed to the buffer after this cycle's pop; at most two may be outstanding.
  assign w_credit  = {1'b0, w_occ} + {2'b0, r_rd_q} - {2'b0, w_pop};
  assign w_cnt_end = (r_cnt == CW'(LOAD_CYCLES - 1));
  // Once the FSM has left the frame (abort -> FLUSH), an in-flight word is simply not captured.
  assign w_push    = r_rd_q && ((r_state == ST_STREAM) || (r_state == ST_DRAIN));

  always_ff @(posedge CTRL_CLK or negedge RESET_N) begin
    if (!RESET_N) r_state <= ST_IDLE;
    else          r_state <= w_nxt;
  end

  always_comb begin
    w_nxt  = r_state;
    w_load = 1'b0;
    w_rd   = 1'b0;
    w_clr  = 1'b0;
    case (r_state)
      ST_IDLE:   if (w_accept) w_nxt = ST_LOAD;
      ST_LOAD: begin
        w_load = 1'b1;
        if (abort) begin
          w_clr = 1'b1;
          w_nxt = ST_FLUSH;
        end else if (w_cnt_end) w_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        if (abort) begin
          w_clr = 1'b1;
          w_nxt = ST_FLUSH;
        end else begin
          w_rd = !RD_EMPTY && (r_issued < {1'b0, r_words}) && (w_credit < 3'd2);
          if (r_issued == {1'b0, r_words}) w_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          w_clr = 1'b1;
          w_nxt = ST_FLUSH;
        end else if ((w_occ == 2'd0) && !r_rd_q) w_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        w_load = 1'b1;
        if (w_cnt_end) w_nxt = ST_DONE;
      end
      ST_DONE:   w_nxt = ST_IDLE;
      default:   w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CTRL_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_words   <= '0;
      r_rd_addr <= '0;
      r_rd_max  <= '0;
      r_rd_len  <= '0;
      r_issued  <= '0;
      r_sent    <= '0;
      r_cnt     <= '0;
      r_rd_q    <= 1'b0;
      r_err     <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_rd_q <= w_rd;
      r_err  <= w_reject;
      // The pulse counter restarts on every state change, so the LOAD and FLUSH pulses each get the full width.
      if (w_nxt != r_state) r_cnt <= '0;
      else if (w_load)      r_cnt <= r_cnt + 1'b1;
      if (w_accept) begin
        r_words   <= frame_words;
        r_rd_addr <= frame_base;
        r_rd_max  <= w_sum[ASIZE-1:0];
        r_rd_len  <= 10'(BURST_LEN);
        r_issued  <= '0;
        r_sent    <= '0;
        r_aborted <= 1'b0;
      end else begin
        if (w_rd)  r_issued  <= r_issued + 1'b1;
        if (w_pop) r_sent    <= r_sent + 1'b1;
        if (w_clr) r_aborted <= 1'b1;
      end
    end
  end

  sdram_rd_skid #(.DW(DSIZE)) u_skid (
    .CTRL_CLK (CTRL_CLK),
    .RESET_N  (RESET_N),
    .i_clr    (w_clr),
    .i_push   (w_push),
    .i_data   (RD_DATA),
    .o_data   (m_data),
    .o_valid  (m_valid),
    .i_ready  (m_ready),
    .o_occ    (w_occ)
  );

  assign busy        = state_busy(r_state);
  assign done        = (r_state == ST_DONE);
  assign aborted     = (r_state == ST_DONE) && r_aborted;
  assign err         = r_err;
  assign RD_ADDR     = r_rd_addr;
  assign RD_MAX_ADDR = r_rd_max;
  assign RD_LENGTH   = r_rd_len;
  assign RD_LOAD     = w_load;
  assign RD          = w_rd;
  assign m_last      = m_valid && (r_sent == ({1'b0, r_words} - 1'b1));

endmodule

// File: tb/tb_sdram_frame_reader.sv
// Self-checking bench for sdram_frame_reader. An SDRAM port model returns
// address-derived data. A table of frame requests is applied in a loop, and
// hand-written sequences cover abort, reset and start-while-busy. Expected
// beats are queued when a start is driven and popped when the DUT emits a beat.
module tb_sdram_frame_reader;

  localparam int AW = 22;
  localparam int DW = 16;

  logic          CTRL_CLK, RESET_N, start, abort;
  logic [AW-1:0] frame_base, frame_words;
  logic          busy, done, aborted, err;
  logic [AW-1:0] RD_ADDR, RD_MAX_ADDR;
  logic [9:0]    RD_LENGTH;
  logic          RD_LOAD, RD;
  logic [DW-1:0] RD_DATA = '0;
  logic          RD_EMPTY;
  logic [15:0]   RD_USE;
  logic [DW-1:0] m_data;
  logic          m_valid, m_ready, m_last;

  sdram_frame_reader #(.BURST_LEN(256), .LOAD_CYCLES(4)) dut (
    .CTRL_CLK(CTRL_CLK), .RESET_N(RESET_N), .start(start), .abort(abort),
    .frame_base(frame_base), .frame_words(frame_words),
    .busy(busy), .done(done), .aborted(aborted), .err(err),
    .RD_ADDR(RD_ADDR), .RD_MAX_ADDR(RD_MAX_ADDR), .RD_LENGTH(RD_LENGTH),
    .RD_LOAD(RD_LOAD), .RD(RD), .RD_DATA(RD_DATA), .RD_EMPTY(RD_EMPTY),
    .RD_USE(RD_USE), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last)
  );

  typedef struct packed { logic [DW-1:0] d; logic last; } exp_t;
  typedef struct {
    logic [AW-1:0] base, words, max;
    int            rdy, emp;
    bit            bad, poke;
  } vec_t;

  exp_t          exp_q[$];
  int            npass = 0, ntotal = 0, cyc = 0;
  int            ready_pct = 100, empty_pct = 0;
  int            nloads, load_rise[2], load_len[2], first_rd_cyc, first_valid_cyc;
  int            first_beat_cyc, last_beat_cyc, beats, ndone, nerr, done_cyc, err_cyc;
  int            stall_viol, credit_viol, rd_empty_viol, outst, start_cyc;
  bit            done_aborted, busy_at_done;
  bit            prev_stall = 0, prev_abort = 0, prev_load = 0, prev_last = 0;
  logic [DW-1:0] prev_data = '0;
  logic [AW-1:0] ptr = '0;

  initial begin
    CTRL_CLK = 1'b0;
    forever #5 CTRL_CLK = ~CTRL_CLK;
  end

  function automatic logic [DW-1:0] memval(input logic [AW-1:0] a);
    return a[15:0] ^ 16'h5A5A ^ {a[21:16], 10'd0};
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    ntotal++;
    if (act == exp) npass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // SDRAM port model: RD_LOAD reloads the read pointer, and each RD returns the
  // next word one cycle later. The pointer wraps at RD_MAX_ADDR, as the controller's does.
  always @(posedge CTRL_CLK) begin
    cyc <= cyc + 1;
    if (RD_LOAD) ptr <= RD_ADDR;
    else if (RD) begin
      RD_DATA <= memval(ptr);
      ptr     <= (ptr + 22'd1 == RD_MAX_ADDR) ? RD_ADDR : ptr + 22'd1;
    end
  end

  // Drive the random ready/empty inputs at the falling edge, then observe the
  // settled values that the next rising edge will act on.
  always @(negedge CTRL_CLK) begin
    bit   beat;
    exp_t e;
    m_ready  = (ready_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < 32'(ready_pct));
    RD_EMPTY = ($urandom_range(0, 99) < 32'(empty_pct));
    RD_USE   = RD_EMPTY ? 16'd0 : 16'd8;
    #1;
    beat = m_valid && m_ready;
    if (RD && RD_EMPTY) rd_empty_viol++;
    if (RD && first_rd_cyc < 0) first_rd_cyc = cyc;
    if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (RD_LOAD && !prev_load) begin
      if (nloads < 2) load_rise[nloads] = cyc;
      nloads++;
    end
    if (RD_LOAD && nloads >= 1 && nloads <= 2) load_len[nloads-1]++;
    if (RD_LOAD) outst = 0;
    else begin
      outst = outst + (RD ? 1 : 0) - (beat ? 1 : 0);
      if (outst > 2) credit_viol++;
    end
    if (RESET_N && prev_stall && !prev_abort &&
        !(m_valid && m_data == prev_data && m_last == prev_last)) stall_viol++;
    if (beat) begin
      if (exp_q.size() == 0) chk("beat_unexpected", {m_data, m_last}, -1);
      else begin
        e = exp_q.pop_front();
        chk("beat", {m_data, m_last}, {e.d, e.last});
      end
      if (first_beat_cyc < 0) first_beat_cyc = cyc;
      last_beat_cyc = cyc;
      beats++;
    end
    if (done) begin
      ndone++; done_cyc = cyc; done_aborted = aborted; busy_at_done = busy;
    end
    if (err) begin nerr++; err_cyc = cyc; end
    prev_stall = RESET_N && m_valid && !m_ready;
    prev_data  = m_data;
    prev_last  = m_last;
    prev_load  = RD_LOAD;
    prev_abort = abort;
  end

  task automatic clear_stats();
    nloads = 0; load_rise[0] = -1; load_rise[1] = -1; load_len[0] = 0; load_len[1] = 0;
    first_rd_cyc = -1; first_valid_cyc = -1; first_beat_cyc = -1; last_beat_cyc = -1;
    beats = 0; ndone = 0; nerr = 0; done_cyc = -1; err_cyc = -1;
    done_aborted = 0; busy_at_done = 1; stall_viol = 0; credit_viol = 0;
    rd_empty_viol = 0; outst = 0;
  endtask

  task automatic issue_start(input logic [AW-1:0] b, input logic [AW-1:0] w, input bit good);
    @(negedge CTRL_CLK);
    clear_stats();
    frame_base = b; frame_words = w; start = 1'b1; start_cyc = cyc;
    if (good) for (int i = 0; i < int'(w); i++)
      exp_q.push_back('{d: memval(b + 22'(i)), last: (i == int'(w) - 1)});
    @(negedge CTRL_CLK);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (ndone == 0 && n < budget) begin
      @(negedge CTRL_CLK); #2; n++;
    end
    chk("done_seen", ndone, 1);
  endtask

  task automatic wait_beats(input int nb, input int budget);
    int n = 0;
    while (beats < nb && n < budget) begin
      @(negedge CTRL_CLK); #2; n++;
    end
    chk("beats_reached", beats >= nb, 1);
  endtask

  task automatic run_vec(input vec_t v);
    ready_pct = v.rdy; empty_pct = v.emp;
    issue_start(v.base, v.words, !v.bad);
    if (v.poke) begin
      // A start that would be rejected in IDLE must be silently ignored while busy.
      repeat (10) @(negedge CTRL_CLK);
      frame_base = 22'h55; frame_words = 22'd300; start = 1'b1;
      @(negedge CTRL_CLK);
      start = 1'b0;
    end
    if (v.bad) begin
      repeat (6) @(negedge CTRL_CLK);
      #2;
      chk("err_cycle", err_cyc, start_cyc + 1);
      chk("err_count", nerr, 1);
      chk("bad_no_load", nloads, 0);
      chk("bad_not_busy", busy, 0);
    end else begin
      wait_done(20000);
      chk("rd_addr", RD_ADDR, v.base);
      chk("rd_max_addr", RD_MAX_ADDR, v.max);
      chk("rd_length", RD_LENGTH, 256);
      chk("load_rise", load_rise[0], start_cyc + 1);
      chk("load_len", load_len[0], 4);
      chk("first_rd_not_early", first_rd_cyc >= start_cyc + 5, 1);
      chk("read_latency", first_valid_cyc, first_rd_cyc + 2);
      chk("beat_count", beats, v.words);
      chk("queue_drained", exp_q.size(), 0);
      chk("flush_rise", load_rise[1], last_beat_cyc + 2);
      chk("flush_len", load_len[1], 4);
      chk("load_pulses", nloads, 2);
      chk("done_cycle", done_cyc, last_beat_cyc + 6);
      chk("done_aborted", done_aborted, 0);
      chk("busy_low_at_done", busy_at_done, 0);
      chk("no_err", nerr, 0);
      chk("stall_hold", stall_viol, 0);
      chk("credit_le_2", credit_viol, 0);
      chk("no_rd_when_empty", rd_empty_viol, 0);
      if (v.rdy >= 100 && v.emp == 0) chk("throughput", last_beat_cyc - first_beat_cyc, v.words - 1);
    end
    exp_q.delete();
    repeat (2) @(negedge CTRL_CLK);
  endtask

  vec_t vecs[8];
  vec_t v;
  int   abort_cyc;

  initial begin
    vecs[0] = '{base: 22'h001000, words: 22'd512, max: 22'h001200, rdy: 100, emp: 0,  bad: 0, poke: 0};
    vecs[1] = '{base: 22'h000000, words: 22'd300, max: 22'h0,      rdy: 100, emp: 0,  bad: 1, poke: 0};
    vecs[2] = '{base: 22'h000000, words: 22'd0,   max: 22'h0,      rdy: 100, emp: 0,  bad: 1, poke: 0};
    vecs[3] = '{base: 22'h3FFF00, words: 22'd512, max: 22'h0,      rdy: 100, emp: 0,  bad: 1, poke: 0};
    vecs[4] = '{base: 22'h3FFF00, words: 22'd256, max: 22'h0,      rdy: 100, emp: 0,  bad: 1, poke: 0};
    vecs[5] = '{base: 22'h3FFE00, words: 22'd256, max: 22'h3FFF00, rdy: 30,  emp: 50, bad: 0, poke: 0};
    vecs[6] = '{base: 22'h002345, words: 22'd768, max: 22'h002645, rdy: 30,  emp: 50, bad: 0, poke: 0};
    vecs[7] = '{base: 22'h000010, words: 22'd256, max: 22'h000110, rdy: 100, emp: 30, bad: 0, poke: 0};

    RESET_N = 1'b0; start = 1'b0; abort = 1'b0; frame_base = '0; frame_words = '0;
    clear_stats();
    #3;
    chk("reset_ctrl", {busy, done, aborted, err, RD_LOAD, RD, m_valid, m_last}, 0);
    chk("reset_addr", {RD_ADDR, RD_MAX_ADDR, RD_LENGTH}, 0);
    chk("reset_data", m_data, 0);
    repeat (3) @(negedge CTRL_CLK);
    RESET_N = 1'b1;
    repeat (2) @(negedge CTRL_CLK);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Abort in the middle of the stream.
    ready_pct = 100; empty_pct = 0;
    issue_start(22'h004000, 22'd512, 1'b1);
    wait_beats(101, 2000);
    @(negedge CTRL_CLK);
    abort = 1'b1; abort_cyc = cyc;
    @(negedge CTRL_CLK);
    abort = 1'b0;
    exp_q.delete();
    #2;
    chk("abort_valid_drop", m_valid, 0);
    wait_done(200);
    chk("abort_flag", done_aborted, 1);
    chk("abort_flush_rise", load_rise[1], abort_cyc + 1);
    chk("abort_flush_len", load_len[1], 4);
    chk("abort_done_cycle", done_cyc, abort_cyc + 5);
    repeat (2) @(negedge CTRL_CLK);
    v = '{base: 22'h008000, words: 22'd256, max: 22'h008100, rdy: 100, emp: 0, bad: 0, poke: 0};
    run_vec(v);

    // Reset asserted mid-stream.
    issue_start(22'h000000, 22'd512, 1'b1);
    wait_beats(50, 2000);
    @(negedge CTRL_CLK);
    RESET_N = 1'b0;
    #1;
    chk("midreset_ctrl", {busy, done, aborted, err, RD_LOAD, RD, m_valid, m_last}, 0);
    chk("midreset_addr", {RD_ADDR, RD_MAX_ADDR, RD_LENGTH}, 0);
    chk("midreset_data", m_data, 0);
    @(negedge CTRL_CLK);
    RESET_N = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge CTRL_CLK);
    #2;
    chk("midreset_idle", {busy, RD_LOAD, m_valid}, 0);

    // A frame after reset, with a start poked while busy.
    v = '{base: 22'h000100, words: 22'd256, max: 22'h000200, rdy: 100, emp: 20, bad: 0, poke: 1};
    run_vec(v);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
